// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
//
// UART receiver. It turns the asynchronous serial RX line into parallel bytes
// with a single-cycle valid strobe. The block contains:
//   - a two-flop input synchronizer,
//   - a free-running oversampling tick generator,
//   - a frame FSM (8N1 by default).
// o_data / o_data_valid feed i_uart_data / i_uart_data_valid of the downstream
// UART-to-ALU interface FSM.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : a PARITY state sits between DATA and STOP. PARITY_ODD selects
//               even (0) or odd (1) parity.
//   undefined : the frame has no parity bit and o_parity_error is tied to 0.
//
// Parameters:
//   NB_DATA        data bits per frame, sent LSB first
//   CLKS_PER_TICK  clock cycles per oversample tick
//   N_OVERSAMPLE   ticks per bit period (even, >= 4)
//   NB_TICK_CNT    tick divider width, 2**NB_TICK_CNT >= CLKS_PER_TICK
//   PARITY_ODD     0 = even parity, 1 = odd parity
//
// Ports:
//   i_clock         system clock, rising edge
//   i_reset         asynchronous active-high reset
//   i_rx            serial line, idle high, asynchronous to i_clock
//   o_data          last correctly received byte (held between frames)
//   o_data_valid    one-cycle pulse when o_data is updated
//   o_frame_error   one-cycle pulse when the stop bit samples 0
//   o_parity_error  one-cycle pulse on parity mismatch
// -----------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int NB_DATA       = 8,
    parameter int CLKS_PER_TICK = 326,
    parameter int N_OVERSAMPLE  = 16,
    parameter int NB_TICK_CNT   = 9,
    parameter int PARITY_ODD    = 0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_data_valid,
    output logic               o_frame_error,
    output logic               o_parity_error
);

    localparam int NB_SAMPLE_CNT = $clog2(N_OVERSAMPLE);
    localparam int NB_BIT_CNT    = $clog2(NB_DATA) + 1;

    localparam logic [NB_TICK_CNT-1:0]   TICK_LAST   = NB_TICK_CNT'(CLKS_PER_TICK - 1);
    localparam logic [NB_TICK_CNT-1:0]   TICK_ZERO   = NB_TICK_CNT'(0);
    localparam logic [NB_TICK_CNT-1:0]   TICK_ONE    = NB_TICK_CNT'(1);
    localparam logic [NB_SAMPLE_CNT-1:0] SAMPLE_MID  = NB_SAMPLE_CNT'(N_OVERSAMPLE / 2 - 1);
    localparam logic [NB_SAMPLE_CNT-1:0] SAMPLE_LAST = NB_SAMPLE_CNT'(N_OVERSAMPLE - 1);
    localparam logic [NB_SAMPLE_CNT-1:0] SAMPLE_ZERO = NB_SAMPLE_CNT'(0);
    localparam logic [NB_SAMPLE_CNT-1:0] SAMPLE_ONE  = NB_SAMPLE_CNT'(1);
    localparam logic [NB_BIT_CNT-1:0]    BIT_LAST    = NB_BIT_CNT'(NB_DATA - 1);
    localparam logic [NB_BIT_CNT-1:0]    BIT_ZERO    = NB_BIT_CNT'(0);
    localparam logic [NB_BIT_CNT-1:0]    BIT_ONE     = NB_BIT_CNT'(1);
    localparam logic [NB_DATA-1:0]       DATA_ZERO   = NB_DATA'(0);

    // Reject configurations the counters cannot represent.
    if ((N_OVERSAMPLE < 4) || ((N_OVERSAMPLE % 2) != 0) ||
        ((2 ** NB_TICK_CNT) < CLKS_PER_TICK) ||
        (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_cfg
        $error("uart_rx_deserializer: invalid parameter combination");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Expected parity bit for a received data word.
    function automatic logic parity_expected(input logic [NB_DATA-1:0] data);
        return (^data) ^ PARITY_ODD[0];
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    logic                     rx_meta_r;
    logic                     rx_sync_r;
    logic                     rx_s;
    logic [NB_TICK_CNT-1:0]   tick_cnt_r;
    logic                     tick_s;

    state_t                   state_r,      state_next_s;
    logic [NB_SAMPLE_CNT-1:0] sample_cnt_r, sample_cnt_next_s;
    logic [NB_BIT_CNT-1:0]    bit_cnt_r,    bit_cnt_next_s;
    logic [NB_DATA-1:0]       shift_r,      shift_next_s;
    logic [NB_DATA-1:0]       data_r,       data_next_s;
    logic                     valid_r,      valid_next_s;
    logic                     ferr_r,       ferr_next_s;
`ifdef UART_RX_PARITY_EN
    logic                     parity_bit_r, parity_bit_next_s;
    logic                     perr_r,       perr_next_s;
`endif

    // Two-flop synchronizer; flops reset to the idle (high) line level.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= i_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s = rx_sync_r;

    // Free-running oversample tick divider, active in every FSM state.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tick_cnt_r <= TICK_ZERO;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= TICK_ZERO;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
        end
    end

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Frame FSM next-state and output decode; only tick cycles advance it.
    always_comb begin
        state_next_s      = state_r;
        sample_cnt_next_s = sample_cnt_r;
        bit_cnt_next_s    = bit_cnt_r;
        shift_next_s      = shift_r;
        data_next_s       = data_r;
        valid_next_s      = 1'b0;
        ferr_next_s       = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next_s = parity_bit_r;
        perr_next_s       = 1'b0;
`endif
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    sample_cnt_next_s = SAMPLE_ZERO;
                    bit_cnt_next_s    = BIT_ZERO;
                    if (!rx_s) begin
                        state_next_s = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                // Re-check the line half a bit in; a high level here is a glitch.
                ST_START: begin
                    if (sample_cnt_r == SAMPLE_MID) begin
                        sample_cnt_next_s = SAMPLE_ZERO;
                        if (!rx_s) begin
                            state_next_s = ST_DATA;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
                    end else begin
                        sample_cnt_next_s = sample_cnt_r + SAMPLE_ONE;
                    end
                end
                // Sampling is phase-aligned to mid-bit by the START half-bit wait.
                ST_DATA: begin
                    if (sample_cnt_r == SAMPLE_LAST) begin
                        sample_cnt_next_s = SAMPLE_ZERO;
                        shift_next_s      = {rx_s, shift_r[NB_DATA-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_next_s = BIT_ZERO;
`ifdef UART_RX_PARITY_EN
                            state_next_s   = ST_PARITY;
`else
                            state_next_s   = ST_STOP;
`endif
                        end else begin
                            bit_cnt_next_s = bit_cnt_r + BIT_ONE;
                        end
                    end else begin
                        sample_cnt_next_s = sample_cnt_r + SAMPLE_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (sample_cnt_r == SAMPLE_LAST) begin
                        sample_cnt_next_s = SAMPLE_ZERO;
                        parity_bit_next_s = rx_s;
                        state_next_s      = ST_STOP;
                    end else begin
                        sample_cnt_next_s = sample_cnt_r + SAMPLE_ONE;
                    end
                end
`endif
                // Frame error outranks parity error; outputs are mutually exclusive.
                ST_STOP: begin
                    if (sample_cnt_r == SAMPLE_LAST) begin
                        sample_cnt_next_s = SAMPLE_ZERO;
                        state_next_s      = ST_IDLE;
                        if (!rx_s) begin
                            ferr_next_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_bit_r != parity_expected(shift_r)) begin
                            perr_next_s = 1'b1;
`endif
                        end else begin
                            data_next_s  = shift_r;
                            valid_next_s = 1'b1;
                        end
                    end else begin
                        sample_cnt_next_s = sample_cnt_r + SAMPLE_ONE;
                    end
                end
                default: begin
                    state_next_s      = ST_IDLE;
                    sample_cnt_next_s = SAMPLE_ZERO;
                    bit_cnt_next_s    = BIT_ZERO;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state, counters, shift register and registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            sample_cnt_r <= SAMPLE_ZERO;
            bit_cnt_r    <= BIT_ZERO;
            shift_r      <= DATA_ZERO;
            data_r       <= DATA_ZERO;
            valid_r      <= 1'b0;
            ferr_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_r <= 1'b0;
            perr_r       <= 1'b0;
`endif
        end else begin
            state_r      <= state_next_s;
            sample_cnt_r <= sample_cnt_next_s;
            bit_cnt_r    <= bit_cnt_next_s;
            shift_r      <= shift_next_s;
            data_r       <= data_next_s;
            valid_r      <= valid_next_s;
            ferr_r       <= ferr_next_s;
`ifdef UART_RX_PARITY_EN
            parity_bit_r <= parity_bit_next_s;
            perr_r       <= perr_next_s;
`endif
        end
    end

    assign o_data        = data_r;
    assign o_data_valid  = valid_r;
    assign o_frame_error = ferr_r;
`ifdef UART_RX_PARITY_EN
    assign o_parity_error = perr_r;
`else
    assign o_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deserializer
//
// Directed bench for uart_rx_deserializer with CLKS_PER_TICK=4 and
// N_OVERSAMPLE=16, so one bit lasts 64 clocks. A vector table holds single
// frames and their expected pulse counts and data. Hand-written sequences
// cover back-to-back frames, a start glitch, a stuck-low line, reset in
// mid-frame, and parity (when UART_RX_PARITY_EN is defined).
// -----------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int BIT_CLKS = 64;

    logic       i_clock;
    logic       i_reset;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_frame_error;
    logic       o_parity_error;

    uart_rx_deserializer #(
        .NB_DATA       (8),
        .CLKS_PER_TICK (4),
        .N_OVERSAMPLE  (16),
        .NB_TICK_CNT   (2),
        .PARITY_ODD    (0)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_rx           (i_rx),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .o_frame_error  (o_frame_error),
        .o_parity_error (o_parity_error)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [7:0] tx_data;
        logic       stop_bit;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    int n_cmp;
    int n_err;

    // Pulse monitor: counts high cycles of each strobe and logs received data.
    int         valid_cnt;
    int         ferr_cnt;
    int         perr_cnt;
    int         excl_viol;
    logic [7:0] rx_q[$];

    initial begin
        valid_cnt = 0;
        ferr_cnt  = 0;
        perr_cnt  = 0;
        excl_viol = 0;
    end

    always @(negedge i_clock) begin
        if (o_data_valid) begin
            valid_cnt = valid_cnt + 1;
            rx_q.push_back(o_data);
        end
        if (o_frame_error) ferr_cnt = ferr_cnt + 1;
        if (o_parity_error) perr_cnt = perr_cnt + 1;
        if ((o_data_valid && o_frame_error) || (o_data_valid && o_parity_error) ||
            (o_frame_error && o_parity_error)) excl_viol = excl_viol + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        i_rx = b;
        repeat (BIT_CLKS) @(negedge i_clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_bit, input int idle);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`else
        if (par_bit === 1'bx) $display("note: parity bit unknown");
`endif
        send_bit(stop_bit);
        i_rx = 1'b1;
        repeat (idle) @(negedge i_clock);
    endtask

    vec_t vecs[5];
    int   v0, f0, p0, q0;

    initial begin
        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{tx_data: 8'hA5, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'hA5};
        vecs[1] = '{tx_data: 8'h55, stop_bit: 1'b0, exp_valid: 0, exp_ferr: 1, exp_data: 8'hA5};
        vecs[2] = '{tx_data: 8'h00, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h00};
        vecs[3] = '{tx_data: 8'h80, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h80};
        vecs[4] = '{tx_data: 8'h01, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0, exp_data: 8'h01};

        // Reset state
        i_rx    = 1'b1;
        i_reset = 1'b1;
        repeat (5) @(negedge i_clock);
        check("reset_o_data", int'(o_data), 0);
        check("reset_valid", int'(o_data_valid), 0);
        check("reset_ferr", int'(o_frame_error), 0);
        check("reset_perr", int'(o_parity_error), 0);
        i_reset = 1'b0;
        repeat (100) @(negedge i_clock);
        check("idle_no_pulses", valid_cnt + ferr_cnt + perr_cnt, 0);

        // Table-driven single frames
        for (int k = 0; k < 5; k++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            p0 = perr_cnt;
            send_frame(vecs[k].tx_data, vecs[k].stop_bit, ^vecs[k].tx_data, BIT_CLKS);
            check($sformatf("vec%0d_valid_pulses", k), valid_cnt - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr_pulses", k), ferr_cnt - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_perr_pulses", k), perr_cnt - p0, 0);
            check($sformatf("vec%0d_o_data", k), int'(o_data), int'(vecs[k].exp_data));
        end

        // Back-to-back frames without idle gap
        v0 = valid_cnt;
        q0 = rx_q.size();
        send_frame(8'h3C, 1'b1, ^8'h3C, 0);
        send_frame(8'hFF, 1'b1, ^8'hFF, BIT_CLKS);
        check("b2b_valid_pulses", valid_cnt - v0, 2);
        if (rx_q.size() >= q0 + 2) begin
            check("b2b_first_byte", int'(rx_q[q0]), 8'h3C);
            check("b2b_second_byte", int'(rx_q[q0 + 1]), 8'hFF);
        end else begin
            check("b2b_bytes_logged", rx_q.size() - q0, 2);
        end

        // 20-clock start glitch on an idle line
        v0 = valid_cnt;
        f0 = ferr_cnt;
        i_rx = 1'b0;
        repeat (20) @(negedge i_clock);
        i_rx = 1'b1;
        repeat (200) @(negedge i_clock);
        check("glitch_valid_pulses", valid_cnt - v0, 0);
        check("glitch_ferr_pulses", ferr_cnt - f0, 0);
        check("glitch_o_data", int'(o_data), 8'hFF);

        // Line held low: one frame error per ~612 clocks, never valid
        v0 = valid_cnt;
        f0 = ferr_cnt;
        i_rx = 1'b0;
        repeat (1500) @(negedge i_clock);
        check("low_line_ferr_pulses", ferr_cnt - f0, 2);
        check("low_line_valid_pulses", valid_cnt - v0, 0);
        check("low_line_o_data", int'(o_data), 8'hFF);
        i_reset = 1'b1;
        repeat (3) @(negedge i_clock);
        i_rx    = 1'b1;
        i_reset = 1'b0;
        repeat (100) @(negedge i_clock);

        // Reset in the middle of data bit 4 of 0x81, then a clean 0x12
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h81 >> i) & 8'h01) != 8'h00);
        i_rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge i_clock);
        #2 i_reset = 1'b1;
        repeat (3) @(negedge i_clock);
        i_reset = 1'b0;
        i_rx    = 1'b1;
        repeat (700) @(negedge i_clock);
        check("abort_valid_pulses", valid_cnt - v0, 0);
        check("abort_ferr_pulses", ferr_cnt - f0, 0);
        check("abort_o_data_cleared", int'(o_data), 0);
        send_frame(8'h12, 1'b1, ^8'h12, BIT_CLKS);
        check("after_abort_valid_pulses", valid_cnt - v0, 1);
        check("after_abort_o_data", int'(o_data), 8'h12);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1
        v0 = valid_cnt;
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1, BIT_CLKS);
        check("par_ok_valid_pulses", valid_cnt - v0, 1);
        check("par_ok_perr_pulses", perr_cnt - p0, 0);
        check("par_ok_o_data", int'(o_data), 8'h07);
        send_frame(8'h07, 1'b1, 1'b0, BIT_CLKS);
        check("par_bad_valid_pulses", valid_cnt - v0, 1);
        check("par_bad_perr_pulses", perr_cnt - p0, 1);
        // Frame error outranks a parity mismatch
        f0 = ferr_cnt;
        send_frame(8'h07, 1'b0, 1'b0, BIT_CLKS);
        check("par_ferr_priority_ferr", ferr_cnt - f0, 1);
        check("par_ferr_priority_perr", perr_cnt - p0, 1);
        check("par_o_data_held", int'(o_data), 8'h07);
`else
        check("no_parity_perr_total", perr_cnt, 0);
`endif

        check("pulse_exclusivity", excl_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART receiver that turns the serial RX pin into parallel bytes with a single-cycle valid strobe.
- Its o_data / o_data_valid pair drives i_uart_data / i_uart_data_valid of the downstream UART-to-ALU interface FSM.
- Contains its own oversampling tick generator, input synchronizer and frame FSM (8N1 by default).

Parameters:
- NB_DATA, 8, data bits per frame, sent LSB first.
- CLKS_PER_TICK, 326, clock cycles per oversample tick (50 MHz / (9600*16) rounded).
- N_OVERSAMPLE, 16, ticks per bit period; must be even and at least 4.
- NB_TICK_CNT, 9, width of tick divider counter; must satisfy 2^NB_TICK_CNT >= CLKS_PER_TICK.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined.

Ports:
- i_clock  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_rx  input  1  serial line, idle high, asynchronous to i_clock.
- o_data  output  NB_DATA  last correctly received byte.
- o_data_valid  output  1  one-cycle pulse when o_data is updated.
- o_frame_error  output  1  one-cycle pulse when the stop bit samples 0.
- o_parity_error  output  1  one-cycle pulse on parity mismatch; constant 0 without the macro.

Behaviour:
- Reset (async, any cycle, mid-frame included):
  - FSM goes to IDLE; all counters go to 0; synchronizer flops go to 1.
  - o_data = 0; o_data_valid, o_frame_error and o_parity_error = 0.
  - A frame in progress is discarded. No output pulse is produced after reset release until a full new frame is received.
- Synchronizer: two flops on i_rx, giving rx_s. Every reference to "sample" below means rx_s.
- Tick generator:
  - Free-running counter 0..CLKS_PER_TICK-1.
  - tick = 1 for one cycle when the counter equals CLKS_PER_TICK-1; the counter then wraps to 0.
  - It runs in every state.
- FSM states, all advancing only on tick cycles except where noted:
  - IDLE: sample_cnt = 0. When rx_s == 0 on a tick, go to START.
  - START: count ticks. At sample_cnt == N_OVERSAMPLE/2-1, check rx_s:
    - rx_s == 0: clear sample_cnt and go to DATA.
    - rx_s == 1: treat as a glitch and return to IDLE with no output.
  - DATA: count N_OVERSAMPLE ticks per bit. At count N_OVERSAMPLE-1, shift rx_s into the MSB of the shift register (right shift) and increment bit_cnt. After bit NB_DATA-1 is shifted, go to STOP (or PARITY with the macro).
  - STOP: after N_OVERSAMPLE ticks, check rx_s:
    - rx_s == 1: o_data <= shift register and pulse o_data_valid for exactly one i_clock cycle.
    - rx_s == 0: pulse o_frame_error; o_data is unchanged and there is no valid pulse.
    - Either way, return to IDLE on the same tick.
- Latency: the output pulse occurs in the i_clock cycle after the stop-bit sample tick (registered outputs).
- o_data holds its value between frames.
- o_data_valid and the error pulses are mutually exclusive.
- Back-to-back frames: a start bit immediately after the stop bit is detected on the next tick. No idle time is required beyond the stop bit.
- A line held low continuously produces a frame error of 0x00 each frame time. It never produces o_data_valid.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP, lasting N_OVERSAMPLE ticks.
  - Expected parity bit = XOR of the data bits, inverted when PARITY_ODD = 1.
  - On mismatch, o_parity_error pulses in the cycle in which o_data_valid would have pulsed. o_data_valid is suppressed and o_data is unchanged.
  - A frame error takes priority; only o_frame_error pulses.
- UART_RX_PARITY_EN undefined:
  - No PARITY state and no parity logic.
  - o_parity_error is tied to 0.

Test Plan (CLKS_PER_TICK=4, N_OVERSAMPLE=16, so a bit is 64 clocks):
- Send 0xA5 as 8N1 at 64 clocks/bit -> one o_data_valid pulse, o_data = 0xA5, o_frame_error stays 0.
- Send 0x3C and 0xFF back-to-back with no idle gap -> two valid pulses, o_data = 0x3C then 0xFF.
- Drive a 20-clock low glitch on an idle line -> FSM returns to IDLE, no output pulses.
- Send 0x55 with stop bit forced to 0 -> o_frame_error pulses once, no valid pulse, o_data keeps the previous value.
- Assert i_reset mid-way through data bit 4 of 0x81, release it, then send 0x12 -> no pulse for the aborted frame; valid pulse with o_data = 0x12.
- With UART_RX_PARITY_EN and PARITY_ODD=0: send 0x07 with parity bit 1 -> valid pulse, o_data = 0x07. Resend with parity bit 0 -> o_parity_error pulses, no valid pulse.
